// File: rtl/id_unit_pkg.sv
// Shared decode constants for the instruction-decode unit: opcodes, R-type functs,
// ALU operation encodings and the control-strobe bundle.
package id_unit_pkg;

    localparam int unsigned RegAw = 5;

    // Primary opcodes (instruction[31:26])
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    // R-type functs (instruction[5:0])
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluAnd = 4'd2,
        AluOr  = 4'd3,
        AluXor = 4'd4,
        AluNor = 4'd5,
        AluSlt = 4'd6,
        AluLui = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ImmNone,
        ImmSign,
        ImmZero,
        ImmUpper
    } imm_sel_e;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
        logic jump;
    } ctrl_t;

    // Maps an R-type funct to its ALU operation; o_legal is 0 for unsupported functs.
    function automatic alu_op_e funct_to_alu(input logic [5:0] funct, output logic legal);
        legal = 1'b1;
        case (funct)
            FnAdd, FnAddu: funct_to_alu = AluAdd;
            FnSub, FnSubu: funct_to_alu = AluSub;
            FnAnd:         funct_to_alu = AluAnd;
            FnOr:          funct_to_alu = AluOr;
            FnXor:         funct_to_alu = AluXor;
            FnNor:         funct_to_alu = AluNor;
            FnSlt:         funct_to_alu = AluSlt;
            default: begin
                funct_to_alu = AluAdd;
                legal        = 1'b0;
            end
        endcase
    endfunction

endpackage

// File: rtl/id_unit_if.sv
// Bundle between fetch/writeback (master) and the decode unit (slave).
interface id_unit_if #(
    parameter int unsigned WIDTH = 32
);
    import id_unit_pkg::*;

    logic [31:0]       instruction;
    logic              wb_en;
    logic [RegAw-1:0]  wb_addr;
    logic [WIDTH-1:0]  wb_data;

    logic [WIDTH-1:0]  rs_data;
    logic [WIDTH-1:0]  rt_data;
    logic [WIDTH-1:0]  imm_ext;
    logic [RegAw-1:0]  dst_addr;
    logic              reg_write;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
    logic [3:0]        alu_op;
    logic              illegal;
    logic [31:0]       instr_count;

    modport master (
        output instruction, wb_en, wb_addr, wb_data,
        input  rs_data, rt_data, imm_ext, dst_addr, reg_write, alu_src, mem_read, mem_write,
               mem_to_reg, branch, jump, alu_op, illegal, instr_count
    );

    modport slave (
        input  instruction, wb_en, wb_addr, wb_data,
        output rs_data, rt_data, imm_ext, dst_addr, reg_write, alu_src, mem_read, mem_write,
               mem_to_reg, branch, jump, alu_op, illegal, instr_count
    );

endinterface

// File: rtl/id_unit_regfile_2r1w.sv
// Two-read one-write register file. r0 is hardwired to zero, reads are combinational
// with write-through bypass so a same-cycle writeback is visible to decode.
module regfile_2r1w
    import id_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [RegAw-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [RegAw-1:0] i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [RegAw-1:0] i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [NREGS];
    logic             w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != '0) && (32'(i_waddr) < NREGS);

    // Storage: async clear, write on rising edge, r0 never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port A with bypass from the writeback port
    always_comb begin
        o_rdata_a = '0;
        if (i_raddr_a != '0) begin
            if (w_wr_ok && (i_waddr == i_raddr_a)) begin
                o_rdata_a = i_wdata;
            end else if (32'(i_raddr_a) < NREGS) begin
                o_rdata_a = r_mem[i_raddr_a];
            end
        end
    end

    // Read port B with bypass from the writeback port
    always_comb begin
        o_rdata_b = '0;
        if (i_raddr_b != '0) begin
            if (w_wr_ok && (i_waddr == i_raddr_b)) begin
                o_rdata_b = i_wdata;
            end else if (32'(i_raddr_b) < NREGS) begin
                o_rdata_b = r_mem[i_raddr_b];
            end
        end
    end

endmodule

// File: rtl/id_unit.sv
// Instruction decode unit: register-file read, control decode, immediate extension and a
// running count of legally decoded instructions. Decode is purely combinational.
module id_unit
    import id_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 32
) (
    input logic      clk,
    input logic      rst,
    id_unit_if.slave bus
);

    logic [5:0]       w_opcode;
    logic [5:0]       w_funct;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic [15:0]      w_imm;
    logic [4:0]       w_unused_shamt;

    ctrl_t            w_ctrl;
    alu_op_e          w_alu_op;
    imm_sel_e         w_imm_sel;
    logic             w_use_rd;
    logic             w_illegal;
    logic             w_funct_legal;
    alu_op_e          w_funct_alu;
    logic [WIDTH-1:0] w_imm_ext;
    logic [31:0]      r_instr_count;

    assign w_opcode       = bus.instruction[31:26];
    assign w_rs           = bus.instruction[25:21];
    assign w_rt           = bus.instruction[20:16];
    assign w_rd           = bus.instruction[15:11];
    assign w_unused_shamt = bus.instruction[10:6];
    assign w_funct        = bus.instruction[5:0];
    assign w_imm          = bus.instruction[15:0];

    regfile_2r1w #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (bus.wb_en),
        .i_waddr   (bus.wb_addr),
        .i_wdata   (bus.wb_data),
        .i_raddr_a (w_rs),
        .o_rdata_a (bus.rs_data),
        .i_raddr_b (w_rt),
        .o_rdata_b (bus.rt_data)
    );

    // R-type funct lookup, used only when the opcode is R-type
    always_comb begin
        w_funct_legal = 1'b0;
        w_funct_alu   = funct_to_alu(w_funct, w_funct_legal);
    end

    // Main control decode; an illegal encoding squashes every strobe
    always_comb begin
        w_ctrl    = '0;
        w_alu_op  = AluAdd;
        w_imm_sel = ImmNone;
        w_use_rd  = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OpRtype: begin
                w_use_rd         = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_alu_op         = w_funct_alu;
                w_illegal        = !w_funct_legal;
            end
            OpLw: begin
                w_imm_sel         = ImmSign;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            OpSw: begin
                w_imm_sel        = ImmSign;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            // Fetch tells beq from bne by instruction[26]
            OpBeq, OpBne: begin
                w_alu_op      = AluSub;
                w_imm_sel     = ImmSign;
                w_ctrl.branch = 1'b1;
            end
            OpAddi: begin
                w_imm_sel        = ImmSign;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OpSlti: begin
                w_alu_op         = AluSlt;
                w_imm_sel        = ImmSign;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OpAndi: begin
                w_alu_op         = AluAnd;
                w_imm_sel        = ImmZero;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OpOri: begin
                w_alu_op         = AluOr;
                w_imm_sel        = ImmZero;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OpLui: begin
                w_alu_op         = AluLui;
                w_imm_sel        = ImmUpper;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OpJ: begin
                w_ctrl.jump = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (w_illegal) begin
            w_ctrl = '0;
        end
    end

    // Immediate extension selected by the decoded instruction class
    always_comb begin
        w_imm_ext = '0;
        case (w_imm_sel)
            ImmSign:  w_imm_ext = WIDTH'(signed'(w_imm));
            ImmZero:  w_imm_ext = WIDTH'(w_imm);
            ImmUpper: w_imm_ext = WIDTH'({w_imm, 16'h0000});
            default:  w_imm_ext = '0;
        endcase
    end

    // Count legal decodes; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr_count <= '0;
        end else if (!w_illegal) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign bus.imm_ext     = w_imm_ext;
    assign bus.dst_addr    = w_use_rd ? w_rd : w_rt;
    assign bus.reg_write   = w_ctrl.reg_write;
    assign bus.alu_src     = w_ctrl.alu_src;
    assign bus.mem_read    = w_ctrl.mem_read;
    assign bus.mem_write   = w_ctrl.mem_write;
    assign bus.mem_to_reg  = w_ctrl.mem_to_reg;
    assign bus.branch      = w_ctrl.branch;
    assign bus.jump        = w_ctrl.jump;
    assign bus.alu_op      = w_alu_op;
    assign bus.illegal     = w_illegal;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_id_unit.sv
// Directed bench for id_unit: decode table plus hand sequences for register file,
// bypass, illegal handling and asynchronous reset.
module tb_id_unit;
    import id_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_unit_if #(.WIDTH(32)) bus ();

    id_unit #(
        .WIDTH (32),
        .NREGS (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_count = 32'd0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [6:0]  ctrl;   // {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump}
        logic [3:0]  alu;
        logic        ill;
        logic        chk_fields;
        logic        chk_alu;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {OpRtype, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Opcode 0x3F is unsupported, so the counter holds while this is presented
    function automatic logic [31:0] idle(input logic [4:0] rs, input logic [4:0] rt);
        return {6'h3F, rs, rt, 16'h0000};
    endfunction

    function automatic logic [31:0] ctrl_now();
        return 32'({bus.reg_write, bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                    bus.branch, bus.jump});
    endfunction

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        @(negedge clk);
        bus.wb_en   = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"add",   mk_r(5'd5, 5'd0, 5'd7, FnAdd),       32'h0, 5'd7,  7'b1000000, AluAdd, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{"addu",  mk_r(5'd1, 5'd2, 5'd3, FnAddu),      32'h0, 5'd3,  7'b1000000, AluAdd, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{"sub",   mk_r(5'd1, 5'd2, 5'd4, FnSub),       32'h0, 5'd4,  7'b1000000, AluSub, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{"subu",  mk_r(5'd1, 5'd2, 5'd5, FnSubu),      32'h0, 5'd5,  7'b1000000, AluSub, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{"and",   mk_r(5'd1, 5'd2, 5'd6, FnAnd),       32'h0, 5'd6,  7'b1000000, AluAnd, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{"or",    mk_r(5'd1, 5'd2, 5'd8, FnOr),        32'h0, 5'd8,  7'b1000000, AluOr,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{"xor",   mk_r(5'd1, 5'd2, 5'd9, FnXor),       32'h0, 5'd9,  7'b1000000, AluXor, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{"nor",   mk_r(5'd1, 5'd2, 5'd10, FnNor),      32'h0, 5'd10, 7'b1000000, AluNor, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{"slt",   mk_r(5'd1, 5'd2, 5'd31, FnSlt),      32'h0, 5'd31, 7'b1000000, AluSlt, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{"badfn", mk_r(5'd1, 5'd2, 5'd3, 6'h3F),       32'h0, 5'd0,  7'b0000000, AluAdd, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{"lw",    mk_i(OpLw,   5'd2, 5'd4, 16'h8004),  32'hFFFF8004, 5'd4,  7'b1110100, AluAdd, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{"sw",    mk_i(OpSw,   5'd2, 5'd4, 16'h0010),  32'h00000010, 5'd4,  7'b0101000, AluAdd, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{"beq",   mk_i(OpBeq,  5'd1, 5'd2, 16'hFFFE),  32'hFFFFFFFE, 5'd2,  7'b0000010, AluSub, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{"bne",   mk_i(OpBne,  5'd1, 5'd2, 16'h0003),  32'h00000003, 5'd2,  7'b0000010, AluSub, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{"addi",  mk_i(OpAddi, 5'd1, 5'd12, 16'hFFFF), 32'hFFFFFFFF, 5'd12, 7'b1100000, AluAdd, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{"slti",  mk_i(OpSlti, 5'd1, 5'd13, 16'h7FFF), 32'h00007FFF, 5'd13, 7'b1100000, AluSlt, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{"andi",  mk_i(OpAndi, 5'd1, 5'd14, 16'h8000), 32'h00008000, 5'd14, 7'b1100000, AluAnd, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{"ori",   mk_i(OpOri,  5'd1, 5'd15, 16'hFFFF), 32'h0000FFFF, 5'd15, 7'b1100000, AluOr,  1'b0, 1'b1, 1'b1};
        vecs[18] = '{"lui",   mk_i(OpLui,  5'd0, 5'd16, 16'h1234), 32'h12340000, 5'd16, 7'b1100000, AluLui, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{"j",     mk_i(OpJ,    5'd3, 5'd11, 16'h1234), 32'h00000000, 5'd11, 7'b0000001, AluAdd, 1'b0, 1'b1, 1'b0};

        rst             = 1'b0;
        bus.instruction = idle(5'd0, 5'd0);
        bus.wb_en       = 1'b0;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("count_in_reset", bus.instr_count, 32'h0);
        rst = 1'b1;
        for (int r = 0; r < 32; r++) begin
            bus.instruction = idle(5'(r), 5'(r));
            #1;
            check($sformatf("rst_rs_r%0d", r), bus.rs_data, 32'h0);
            check($sformatf("rst_rt_r%0d", r), bus.rt_data, 32'h0);
        end
        check("count_after_reset", bus.instr_count, 32'h0);

        // Write r5, then read it through add r7,r5,r0
        wr(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        bus.instruction = mk_r(5'd5, 5'd0, 5'd7, FnAdd);
        #1;
        check("add_rs_data", bus.rs_data, 32'hDEADBEEF);
        check("add_rt_data", bus.rt_data, 32'h0);
        check("add_dst", 32'(bus.dst_addr), 32'd7);
        check("add_alu", 32'(bus.alu_op), 32'(AluAdd));
        check("add_reg_write", 32'(bus.reg_write), 32'd1);
        @(negedge clk);
        bus.instruction = idle(5'd0, 5'd0);
        exp_count++;
        #1;
        check("add_count", bus.instr_count, exp_count);

        // r0 ignores writes
        wr(5'd0, 32'h00001234);
        bus.instruction = idle(5'd0, 5'd0);
        #1;
        check("r0_after_write", bus.rs_data, 32'h0);

        // Same-cycle writeback bypass to r9
        @(negedge clk);
        bus.instruction = idle(5'd9, 5'd8);
        bus.wb_en       = 1'b1;
        bus.wb_addr     = 5'd9;
        bus.wb_data     = 32'hCAFEF00D;
        #1;
        check("bypass_rs", bus.rs_data, 32'hCAFEF00D);
        check("bypass_rt_other", bus.rt_data, 32'h0);
        @(negedge clk);
        bus.wb_en = 1'b0;
        #1;
        check("r9_stored", bus.rs_data, 32'hCAFEF00D);

        // Bypass must not leak through r0
        @(negedge clk);
        bus.instruction = idle(5'd0, 5'd0);
        bus.wb_en       = 1'b1;
        bus.wb_addr     = 5'd0;
        bus.wb_data     = 32'h55555555;
        #1;
        check("bypass_r0", bus.rs_data, 32'h0);
        @(negedge clk);
        bus.wb_en = 1'b0;

        // Decode table: one rising edge per vector
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.instruction = vecs[i].instr;
            #1;
            check({vecs[i].name, "_ctrl"}, ctrl_now(), 32'(vecs[i].ctrl));
            check({vecs[i].name, "_illegal"}, 32'(bus.illegal), 32'(vecs[i].ill));
            if (vecs[i].chk_fields) begin
                check({vecs[i].name, "_imm"}, bus.imm_ext, vecs[i].imm);
                check({vecs[i].name, "_dst"}, 32'(bus.dst_addr), 32'(vecs[i].dst));
            end
            if (vecs[i].chk_alu) begin
                check({vecs[i].name, "_alu"}, 32'(bus.alu_op), 32'(vecs[i].alu));
            end
            @(negedge clk);
            bus.instruction = idle(5'd0, 5'd0);
            if (!vecs[i].ill) exp_count++;
            #1;
            check({vecs[i].name, "_count"}, bus.instr_count, exp_count);
        end

        // Illegal opcode held for several edges, then bne
        @(negedge clk);
        bus.instruction = mk_i(6'h3F, 5'd1, 5'd2, 16'h0000);
        #1;
        check("ill_flag", 32'(bus.illegal), 32'd1);
        check("ill_strobes", ctrl_now(), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("ill_count_hold", bus.instr_count, exp_count);
        bus.instruction = mk_i(OpBne, 5'd1, 5'd2, 16'h0004);
        #1;
        check("bne_branch", 32'(bus.branch), 32'd1);
        check("bne_alu", 32'(bus.alu_op), 32'(AluSub));
        @(negedge clk);
        bus.instruction = idle(5'd3, 5'd3);
        exp_count++;
        #1;
        check("bne_count", bus.instr_count, exp_count);

        // Asynchronous reset mid-cycle after writing r3
        wr(5'd3, 32'h33333333);
        bus.instruction = idle(5'd3, 5'd3);
        #1;
        check("r3_written", bus.rs_data, 32'h33333333);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_r3", bus.rs_data, 32'h0);
        check("async_rst_count", bus.instr_count, 32'h0);
        exp_count = 32'h0;

        // A write presented while reset is held is lost
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd3;
        bus.wb_data = 32'hA5A5A5A5;
        @(negedge clk);
        bus.wb_en = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_write_lost", bus.rs_data, 32'h0);

        // Counter restarts from zero
        @(negedge clk);
        bus.instruction = mk_r(5'd1, 5'd2, 5'd3, FnOr);
        @(negedge clk);
        bus.instruction = idle(5'd0, 5'd0);
        exp_count++;
        #1;
        check("count_after_rst", bus.instr_count, exp_count);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
